// File: rtl/pcpi_issuer.sv
// rtl/pcpi_issuer.sv - core-side PCPI initiator with timeout-based illegal instruction detection
//
// Purpose: takes one instruction from the core, presents it on the PCPI bus,
// waits for a co-processor result and hands it back on a valid/ready response
// port. If no co-processor claims the request (pcpi_busy) or answers
// (pcpi_ready) within TIMEOUT_CYCLES consecutive cycles, the request is
// flagged illegal.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             core request handshake
//   req_insn/req_rs1/req_rs2        instruction and operands
//   resp_valid/resp_ready           core response handshake
//   resp_wr/resp_rd/resp_illegal    result write flag, value, illegal flag
//   pcpi_valid/insn/rs1/rs2         registered request to the co-processor
//   pcpi_wr/rd/ready/busy           co-processor result and status

module pcpi_issuer #(
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_insn,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_wr,
   output logic [31:0] resp_rd,
   output logic        resp_illegal,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   output logic [31:0] pcpi_rs1,
   output logic [31:0] pcpi_rs2,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   input  logic        pcpi_ready,
   input  logic        pcpi_busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RESP
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pcpi_valid_q, pcpi_valid_d;
   logic [31:0]       insn_q, insn_d;
   logic [31:0]       rs1_q, rs1_d;
   logic [31:0]       rs2_q, rs2_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_wr_q, resp_wr_d;
   logic [31:0]       resp_rd_q, resp_rd_d;
   logic              resp_illegal_q, resp_illegal_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         pcpi_valid_q   <= 1'b0;
         insn_q         <= '0;
         rs1_q          <= '0;
         rs2_q          <= '0;
         resp_valid_q   <= 1'b0;
         resp_wr_q      <= 1'b0;
         resp_rd_q      <= '0;
         resp_illegal_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pcpi_valid_q   <= pcpi_valid_d;
         insn_q         <= insn_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         resp_valid_q   <= resp_valid_d;
         resp_wr_q      <= resp_wr_d;
         resp_rd_q      <= resp_rd_d;
         resp_illegal_q <= resp_illegal_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      pcpi_valid_d   = pcpi_valid_q;
      insn_d         = insn_q;
      rs1_d          = rs1_q;
      rs2_d          = rs2_q;
      resp_valid_d   = resp_valid_q;
      resp_wr_d      = resp_wr_q;
      resp_rd_d      = resp_rd_q;
      resp_illegal_d = resp_illegal_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               insn_d       = req_insn;
               rs1_d        = req_rs1;
               rs2_d        = req_rs2;
               pcpi_valid_d = 1'b1;
               cnt_d        = '0;
               state_d      = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // Priority: a result beats both busy and the timeout boundary.
            if (pcpi_ready) begin
               resp_wr_d      = pcpi_wr;
               resp_rd_d      = pcpi_wr ? pcpi_rd : 32'd0;
               resp_illegal_d = 1'b0;
               resp_valid_d   = 1'b1;
               pcpi_valid_d   = 1'b0;
               state_d        = ST_RESP;
            end else if (pcpi_busy) begin
               // A claimed request may take arbitrarily long; only silence counts.
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               resp_wr_d      = 1'b0;
               resp_rd_d      = 32'd0;
               resp_illegal_d = 1'b1;
               resp_valid_d   = 1'b1;
               pcpi_valid_d   = 1'b0;
               state_d        = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign pcpi_valid   = pcpi_valid_q;
   assign pcpi_insn    = insn_q;
   assign pcpi_rs1     = rs1_q;
   assign pcpi_rs2     = rs2_q;
   assign resp_valid   = resp_valid_q;
   assign resp_wr      = resp_wr_q;
   assign resp_rd      = resp_rd_q;
   assign resp_illegal = resp_illegal_q;

endmodule

// File: doc/pcpi_issuer.md
Name: pcpi_issuer

Overview:
- Core-side PCPI initiator: accepts one custom/M-extension instruction from the core pipeline, drives pcpi_valid/insn/rs1/rs2 to the attached co-processor, and waits for pcpi_ready.
- Returns the co-processor result to the core through a valid/ready response port.
- Flags an illegal instruction when no co-processor claims the request within a bounded number of cycles.
- Sits between the core's execute stage and the PCPI bus that feeds the M unit.

Parameters:
TIMEOUT_CYCLES, 16, consecutive cycles in ISSUE with pcpi_busy=0 and pcpi_ready=0 before the request is declared illegal; legal range 2..255.
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  core presents an instruction
req_ready  out  1  issuer can accept a request
req_insn  in  32  instruction word
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2
resp_valid  out  1  response available
resp_ready  in  1  core accepts the response
resp_wr  out  1  result is to be written to rd
resp_rd  out  32  result value
resp_illegal  out  1  no co-processor claimed the instruction
pcpi_valid  out  1  request valid to the co-processor
pcpi_insn  out  32  registered instruction
pcpi_rs1  out  32  registered operand 1
pcpi_rs2  out  32  registered operand 2
pcpi_wr  in  1  co-processor writes rd
pcpi_rd  in  32  co-processor result
pcpi_ready  in  1  co-processor result valid, one cycle
pcpi_busy  in  1  co-processor claimed the request and is computing

Behaviour:
- Reset (synchronous, active-high):
  - State becomes IDLE; counter = 0.
  - pcpi_valid=0, pcpi_insn/rs1/rs2=0, resp_valid=0, resp_wr=0, resp_rd=0, resp_illegal=0.
  - Reset wins over every other event, including mid-ISSUE and mid-RESP. No response is produced for an aborted request.
- All outputs are registered except req_ready, which equals (state==IDLE).
- IDLE:
  - On req_valid&&req_ready at edge T: capture insn/rs1/rs2 into pcpi_*, set pcpi_valid=1, clear counter, go to ISSUE.
  - pcpi_valid is therefore first high in cycle T+1.
- ISSUE (pcpi_valid=1, pcpi_* held stable):
  - pcpi_ready=1: capture resp_rd = pcpi_wr ? pcpi_rd : 0 and resp_wr = pcpi_wr; set resp_illegal=0, resp_valid=1, pcpi_valid=0; go to RESP. pcpi_valid is low in the cycle after the ready cycle, so the responder, back in its idle state, does not re-accept.
  - else pcpi_busy=1: counter cleared; stay in ISSUE. No upper bound on busy duration.
  - else counter==TIMEOUT_CYCLES-1: resp_illegal=1, resp_wr=0, resp_rd=0, resp_valid=1, pcpi_valid=0; go to RESP.
  - else: counter++.
  - pcpi_ready in the same cycle as the timeout boundary: ready wins; no illegal.
  - pcpi_ready without a prior busy is legal (single-cycle responder).
- RESP:
  - resp_* held stable while resp_ready=0; req_ready=0.
  - On resp_ready=1: resp_valid=0, go to IDLE. resp_wr/resp_rd/resp_illegal keep their values, don't-care when resp_valid=0.
  - No same-cycle re-accept; minimum gap between requests is one IDLE cycle.
- pcpi_ready/pcpi_busy outside ISSUE are ignored.
- Latency: issue edge T to resp_valid = responder ready cycle + 1. Example for the M unit MUL: valid T+1, ready T+3, resp_valid T+4.
- Illegal latency: resp_valid at T+TIMEOUT_CYCLES+1 when the responder is silent. pcpi_valid is high for exactly TIMEOUT_CYCLES cycles.

Test Plan:
1. MUL 0x02B50533, rs1=7, rs2=6; bench responder asserts busy in T+2 and ready+wr with rd=42 in T+3 -> pcpi_valid high T+1..T+3 only; resp_valid T+4 with rd=42, wr=1, illegal=0.
2. ADD 0x00B50533, silent responder, TIMEOUT_CYCLES=16 -> pcpi_valid high exactly 16 cycles; resp_valid with illegal=1, wr=0, rd=0.
3. DIVU rs1=100, rs2=7; busy held 40 cycles then ready with rd=14 -> no timeout; resp_rd=14, wr=1.
4. resp_ready low 5 cycles after resp_valid -> resp_rd/wr/illegal stable, req_ready=0 throughout; a second back-to-back req_valid is accepted only in the IDLE cycle after the handshake.
5. reset asserted while in ISSUE (cycle T+5 of a busy division) -> next cycle pcpi_valid=0, req_ready=1, resp_valid=0; a later pcpi_ready is ignored and produces no response.
6. Silent responder then pcpi_ready with wr=0 exactly at the counter==TIMEOUT_CYCLES-1 cycle -> resp_illegal=0, resp_wr=0, resp_rd=0.
